dsm_decimator: RTL and testbench

Receive-side counterpart of the delta-sigma modulator. It takes the 2-bit ternary `pwm` code stream at the fast `clock` rate and reconstructs 15-bit signed samples at the slow sample rate using a CIC decimation filter. It sits after `dsm_top` in loopback and self-check configurations, so modulator output can be compared directly against the original `vin`.

---
 rtl/dsm_pkg.sv | 17 +
 rtl/dsm_cic_comb.sv | 25 ++
 rtl/dsm_decimator.sv | 125 ++++++++++++
 tb/tb_dsm_decimator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma modulator / decimator pair.
// Holds the ternary code map, the default output width and the CIC width helper.
package dsm_pkg;

   localparam logic [1:0] PWM_POS  = 2'b01;
   localparam logic [1:0] PWM_NEG  = 2'b11;
   localparam logic [1:0] PWM_ZERO = 2'b00;
   localparam logic [1:0] PWM_BAD  = 2'b10;

   localparam int DSM_OUT_W = 15;

   // Two bits cover the signed ternary input; each stage adds log2(DECIM) bits of growth.
   function automatic int cicWidth(input int decim, input int order);
      return 2 + order * $clog2(decim);
   endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// One CIC comb stage: y = x - (x captured on the previous strobe).
// The subtraction is combinational so a chain of these settles within the strobe cycle.
module dsm_cic_comb #(
   parameter int W = 11
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stb_i,
   input  logic signed [W-1:0] x_i,
   output logic signed [W-1:0] y_o
);

   logic signed [W-1:0] z_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         z_q <= '0;
      end else if (stb_i) begin
         z_q <= x_i;
      end
   end

   assign y_o = x_i - z_q;

endmodule

// File: rtl/dsm_decimator.sv
// CIC decimator that rebuilds signed samples from the ternary pwm stream.
// Integrators run every clock; combs, scaling and saturation act once per DECIM clocks.
module dsm_decimator
   import dsm_pkg::*;
#(
   parameter int DECIM = 8,
   parameter int ORDER = 3,
   parameter int OUT_W = DSM_OUT_W
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              pwm,
   output logic signed [OUT_W-1:0] vout,
   output logic                    vout_valid,
   output logic                    code_err
);

   localparam int LOGD  = $clog2(DECIM);
   localparam int W     = cicWidth(DECIM, ORDER);
   localparam int SHIFT = OUT_W - 1 - ORDER * LOGD;
   localparam int SW    = OUT_W + 1;

   localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

   logic signed [W-1:0]     dec_d;
   logic signed [W-1:0]     integ_q [ORDER];
   logic [LOGD-1:0]         cnt_q;
   logic                    stb;
   logic signed [W-1:0]     combOut;
   logic signed [SW-1:0]    scaled;
   logic signed [OUT_W-1:0] sat_d;
   logic signed [OUT_W-1:0] vout_q;
   logic                    voutValid_q;
   logic                    codeErr_q;

   // The invalid code contributes nothing to the filter; it only raises the sticky flag.
   always_comb begin
      dec_d = '0;
      case (pwm)
         PWM_POS:  dec_d = W'(1);
         PWM_NEG:  dec_d = '1;
         default:  dec_d = '0;
      endcase
   end

   // Integrators wrap freely; the combs cancel the wrap as long as W covers the gain.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int k = 0; k < ORDER; k++) begin
            integ_q[k] <= '0;
         end
      end else begin
         integ_q[0] <= integ_q[0] + dec_d;
         for (int k = 1; k < ORDER; k++) begin
            integ_q[k] <= integ_q[k] + integ_q[k-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + LOGD'(1);
      end
   end

   assign stb = (cnt_q == LOGD'(DECIM - 1));

   for (genvar g = 0; g < ORDER; g++) begin : gComb
      logic signed [W-1:0] xIn;
      logic signed [W-1:0] yOut;

      if (g == 0) begin : gFirst
         assign xIn = integ_q[ORDER-1];
      end else begin : gNext
         assign xIn = gComb[g-1].yOut;
      end

      dsm_cic_comb #(
         .W (W)
      ) uComb (
         .clock (clock),
         .reset (reset),
         .stb_i (stb),
         .x_i   (xIn),
         .y_o   (yOut)
      );
   end

   assign combOut = gComb[ORDER-1].yOut;

   // Full-scale positive lands one LSB above the output range, hence the clamp.
   always_comb begin
      scaled = SW'(combOut) <<< SHIFT;
      sat_d  = scaled[OUT_W-1:0];
      if (scaled > MAXV) begin
         sat_d = MAXV[OUT_W-1:0];
      end else if (scaled < MINV) begin
         sat_d = MINV[OUT_W-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         vout_q      <= '0;
         voutValid_q <= 1'b0;
         codeErr_q   <= 1'b0;
      end else begin
         voutValid_q <= stb;
         if (stb) begin
            vout_q <= sat_d;
         end
         if (pwm == PWM_BAD) begin
            codeErr_q <= 1'b1;
         end
      end
   end

   assign vout       = vout_q;
   assign vout_valid = voutValid_q;
   assign code_err   = codeErr_q;

endmodule

// File: tb/tb_dsm_decimator.sv
// Bench for dsm_decimator: an FIR-form CIC reference feeds a scoreboard queue,
// with a table of steady-state patterns plus hand-built reset/error/wrap sequences.
module tb_dsm_decimator;

   localparam int DECIM = 8;
   localparam int ORDER = 3;
   localparam int OUT_W = 15;
   localparam int HLEN  = ORDER * (DECIM - 1) + 1;
   localparam int LAG   = DECIM - 1 - ORDER;
   localparam int SHIFT = OUT_W - 1 - ORDER * $clog2(DECIM);

   logic                    clock;
   logic                    reset;
   logic [1:0]              pwm;
   logic signed [OUT_W-1:0] vout;
   logic                    vout_valid;
   logic                    code_err;

   dsm_decimator #(
      .DECIM (DECIM),
      .ORDER (ORDER),
      .OUT_W (OUT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pwm        (pwm),
      .vout       (vout),
      .vout_valid (vout_valid),
      .code_err   (code_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] pat;
      int         len;
      int         cycles;
      int         steady;
   } vec_t;

   int   h [HLEN];
   int   hist [$];
   int   expQ [$];
   int   edgeIdx;
   int   lastVout;
   logic errModel;
   int   compared;
   int   mismatched;
   int   validCount;

   // Record one comparison and report it on mismatch.
   task automatic checkOutput(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, want %0d (edge %0d)", name, got, want, edgeIdx);
      end
   endtask

   function automatic int decodePwm(input logic [1:0] p);
      if (p == 2'b01) return 1;
      if (p == 2'b11) return -1;
      return 0;
   endfunction

   // Output m is the triple-boxcar FIR of the input, ending LAG samples into its block.
   function automatic int modelVout(input int m);
      int y;
      int s;
      int v;
      y = 0;
      for (int k = 0; k < HLEN; k++) begin
         s = DECIM * m + LAG - k;
         if (s >= 0 && s < hist.size()) y += h[k] * hist[s];
      end
      v = y * (1 << SHIFT);
      if (v > (1 << (OUT_W - 1)) - 1) v = (1 << (OUT_W - 1)) - 1;
      if (v < -(1 << (OUT_W - 1))) v = -(1 << (OUT_W - 1));
      return v;
   endfunction

   task automatic applyReset(input int n, input logic [1:0] p);
      for (int i = 0; i < n; i++) begin
         reset = 1'b0;
         pwm   = p;
         @(posedge clock);
         #1;
         checkOutput("reset_vout", int'(vout), 0);
         checkOutput("reset_valid", int'(vout_valid), 0);
         checkOutput("reset_err", int'(code_err), 0);
      end
      hist.delete();
      expQ.delete();
      edgeIdx  = 0;
      lastVout = 0;
      errModel = 1'b0;
   endtask

   // One non-reset clock: drive p, let the edge consume it, then score the outputs.
   task automatic applyStimulus(input logic [1:0] p);
      logic validExp;
      int   e;
      reset = 1'b1;
      pwm   = p;
      @(posedge clock);
      #1;
      hist.push_back(decodePwm(p));
      if (p == 2'b10) errModel = 1'b1;
      validExp = ((edgeIdx % DECIM) == DECIM - 1);
      if (validExp) expQ.push_back(modelVout(edgeIdx / DECIM));
      checkOutput("valid", int'(vout_valid), int'(validExp));
      if (vout_valid) begin
         validCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("vout", int'(vout), e);
            lastVout = e;
         end
      end else begin
         checkOutput("vout_hold", int'(vout), lastVout);
      end
      checkOutput("code_err", int'(code_err), int'(errModel));
      edgeIdx++;
   endtask

   vec_t vecs [6];

   initial begin
      int tmp [HLEN];
      compared   = 0;
      mismatched = 0;
      validCount = 0;
      reset      = 1'b0;
      pwm        = 2'b00;

      // Build the CIC impulse response as ORDER boxcars of length DECIM convolved.
      for (int k = 0; k < HLEN; k++) h[k] = (k < DECIM) ? 1 : 0;
      for (int o = 1; o < ORDER; o++) begin
         for (int k = 0; k < HLEN; k++) begin
            tmp[k] = 0;
            for (int j = 0; j < DECIM; j++) if (k - j >= 0) tmp[k] += h[k-j];
         end
         for (int k = 0; k < HLEN; k++) h[k] = tmp[k];
      end

      vecs[0] = '{pat: 8'b00_00_00_01, len: 1, cycles: 100, steady: 16383};
      vecs[1] = '{pat: 8'b00_00_00_11, len: 1, cycles: 100, steady: -16384};
      vecs[2] = '{pat: 8'b00_00_00_00, len: 1, cycles: 100, steady: 0};
      vecs[3] = '{pat: 8'b00_00_00_01, len: 2, cycles: 100, steady: 8192};
      vecs[4] = '{pat: 8'b00_00_11_01, len: 2, cycles: 100, steady: 0};
      vecs[5] = '{pat: 8'b00_01_01_01, len: 4, cycles: 100, steady: 12288};

      applyReset(2, 2'b10);

      for (int v = 0; v < 6; v++) begin
         applyReset(1, 2'b00);
         validCount = 0;
         for (int c = 0; c < vecs[v].cycles; c++) begin
            applyStimulus(vecs[v].pat[2*(c % vecs[v].len) +: 2]);
            if (vout_valid && validCount >= 5) checkOutput($sformatf("steady%0d", v), int'(vout), vecs[v].steady);
         end
         checkOutput($sformatf("valid_count%0d", v), validCount, vecs[v].cycles / DECIM);
      end

      // Single invalid code inside a zero run: flag goes sticky, output stays zero.
      applyReset(1, 2'b00);
      for (int c = 0; c < 13; c++) applyStimulus(2'b00);
      applyStimulus(2'b10);
      checkOutput("err_rise", int'(code_err), 1);
      for (int c = 0; c < 30; c++) begin
         applyStimulus(2'b00);
         if (vout_valid) checkOutput("err_vout", int'(vout), 0);
      end
      checkOutput("err_sticky", int'(code_err), 1);
      applyReset(1, 2'b00);
      checkOutput("err_cleared", int'(code_err), 0);

      // Reset at cnt=5 for three cycles with an invalid code present, then a clean restart.
      for (int c = 0; c < 21; c++) applyStimulus(2'b01);
      checkOutput("pre_reset_cnt", edgeIdx % DECIM, 5);
      applyReset(3, 2'b10);
      validCount = 0;
      for (int c = 0; c < 7; c++) applyStimulus(2'b01);
      checkOutput("no_stale_valid", validCount, 0);
      applyStimulus(2'b01);
      checkOutput("first_valid_after_reset", validCount, 1);
      checkOutput("no_err_after_reset", int'(code_err), 0);

      // Long constant run so every integrator wraps many times.
      applyReset(1, 2'b00);
      validCount = 0;
      for (int c = 0; c < 5000; c++) begin
         applyStimulus(2'b01);
         if (vout_valid && validCount >= 5) checkOutput("wrap_vout", int'(vout), 16383);
      end
      checkOutput("wrap_valid_count", validCount, 5000 / DECIM);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
